// File: rtl/reg_scoreboard.sv
// RAW-hazard scoreboard: per-register busy bit, producer tag and latency
// countdown, set by issue ports and cleared by tag-matched writebacks.
module reg_scoreboard #(
  parameter int NUM_REGS  = 128,
  parameter int ADDR_W    = 7,
  parameter int NUM_ISSUE = 2,
  parameter int NUM_WB    = 2,
  parameter int NUM_SRC   = 4,
  parameter int TAG_W     = 4,
  parameter int LAT_W     = 3,
  parameter bit ZERO_FREE = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic [NUM_ISSUE-1:0]        iss_vld,
  input  logic [NUM_ISSUE*ADDR_W-1:0] iss_dst,
  input  logic [NUM_ISSUE*TAG_W-1:0]  iss_tag,
  input  logic [NUM_ISSUE*LAT_W-1:0]  iss_lat,
  input  logic [NUM_WB-1:0]           wb_vld,
  input  logic [NUM_WB*ADDR_W-1:0]    wb_dst,
  input  logic [NUM_WB*TAG_W-1:0]     wb_tag,
  input  logic [NUM_SRC*ADDR_W-1:0]   src_addr,
  output logic [NUM_SRC-1:0]          src_busy,
  output logic [NUM_SRC-1:0]          src_fwd,
  output logic [ADDR_W:0]             busy_cnt
);

  localparam int CW = ADDR_W + 1;

  logic             busy_q [NUM_REGS];
  logic [TAG_W-1:0] tag_q  [NUM_REGS];
  logic [LAT_W-1:0] cnt_q  [NUM_REGS];
  logic             busy_d [NUM_REGS];
  logic [TAG_W-1:0] tag_d  [NUM_REGS];
  logic [LAT_W-1:0] cnt_d  [NUM_REGS];
  logic [CW-1:0]    pop_d;
  logic [ADDR_W-1:0] sa;
  logic              sb;

  // Later stages override earlier ones: countdown < writeback < issue < flush.
  always_comb begin
    pop_d = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      busy_d[r] = busy_q[r];
      tag_d[r]  = tag_q[r];
      cnt_d[r]  = cnt_q[r];
      if (busy_q[r] && cnt_q[r] != '0)
        cnt_d[r] = cnt_q[r] - LAT_W'(1);
      for (int j = 0; j < NUM_WB; j++) begin
        if (wb_vld[j] && busy_q[r] &&
            wb_dst[j*ADDR_W +: ADDR_W] == ADDR_W'(r) &&
            wb_tag[j*TAG_W +: TAG_W] == tag_q[r]) begin
          busy_d[r] = 1'b0;
          cnt_d[r]  = '0;
        end
      end
      for (int i = 0; i < NUM_ISSUE; i++) begin
        if (iss_vld[i] &&
            iss_dst[i*ADDR_W +: ADDR_W] == ADDR_W'(r) &&
            !(ZERO_FREE && r == 0)) begin
          busy_d[r] = 1'b1;
          tag_d[r]  = iss_tag[i*TAG_W +: TAG_W];
          cnt_d[r]  = iss_lat[i*LAT_W +: LAT_W];
        end
      end
      if (flush) begin
        busy_d[r] = 1'b0;
        tag_d[r]  = '0;
        cnt_d[r]  = '0;
      end
      pop_d = pop_d + CW'(busy_d[r]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        busy_q[r] <= 1'b0;
        tag_q[r]  <= '0;
        cnt_q[r]  <= '0;
      end
      busy_cnt <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        busy_q[r] <= busy_d[r];
        tag_q[r]  <= tag_d[r];
        cnt_q[r]  <= cnt_d[r];
      end
      busy_cnt <= pop_d;
    end
  end

  always_comb begin
    src_busy = '0;
    src_fwd  = '0;
    sa       = '0;
    sb       = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      sa = src_addr[s*ADDR_W +: ADDR_W];
      sb = busy_q[sa] && !(ZERO_FREE && sa == '0);
      src_busy[s] = sb;
      src_fwd[s]  = sb && cnt_q[sa] == '0;
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed table, corner sequences and a
// randomized run against a ready-cycle reference model.
module tb_reg_scoreboard;

  logic        clk;
  logic        reset;
  logic        flush;
  logic [1:0]  iss_vld;
  logic [13:0] iss_dst;
  logic [7:0]  iss_tag;
  logic [5:0]  iss_lat;
  logic [1:0]  wb_vld;
  logic [13:0] wb_dst;
  logic [7:0]  wb_tag;
  logic [27:0] src_addr;
  logic [3:0]  src_busy;
  logic [3:0]  src_fwd;
  logic [7:0]  busy_cnt;

  reg_scoreboard dut (
    .clk(clk), .reset(reset), .flush(flush),
    .iss_vld(iss_vld), .iss_dst(iss_dst),
    .iss_tag(iss_tag), .iss_lat(iss_lat),
    .wb_vld(wb_vld), .wb_dst(wb_dst), .wb_tag(wb_tag),
    .src_addr(src_addr), .src_busy(src_busy),
    .src_fwd(src_fwd), .busy_cnt(busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model: a producer is forwardable once the edge count
  // reaches the edge it was issued on plus its latency.
  bit       m_busy [128];
  bit [3:0] m_tag  [128];
  int       m_ready[128];
  int       cyc = 0;

  localparam logic [27:0] SRC_FIX = {7'd12, 7'd9, 7'd7, 7'd5};

  typedef struct {
    logic [1:0] iv;
    logic [6:0] d0; logic [3:0] t0; logic [2:0] l0;
    logic [6:0] d1; logic [3:0] t1; logic [2:0] l1;
    logic [1:0] wv;
    logic [6:0] wd0; logic [3:0] wt0;
    logic [6:0] wd1; logic [3:0] wt1;
    logic [3:0] eb; logic [3:0] ef; logic [7:0] ec;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t v(
    logic [1:0] iv, logic [6:0] d0, logic [3:0] t0, logic [2:0] l0,
    logic [6:0] d1, logic [3:0] t1, logic [2:0] l1,
    logic [1:0] wv, logic [6:0] wd0, logic [3:0] wt0,
    logic [6:0] wd1, logic [3:0] wt1,
    logic [3:0] eb, logic [3:0] ef, logic [7:0] ec);
    vec_t x;
    x.iv = iv; x.d0 = d0; x.t0 = t0; x.l0 = l0;
    x.d1 = d1; x.t1 = t1; x.l1 = l1;
    x.wv = wv; x.wd0 = wd0; x.wt0 = wt0;
    x.wd1 = wd1; x.wt1 = wt1;
    x.eb = eb; x.ef = ef; x.ec = ec;
    return x;
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp)
      $display("FAIL %s got %0h expected %0h t=%0t", nm, got, exp, $time);
    else
      passed++;
  endtask

  task automatic model_clear();
    for (int r = 0; r < 128; r++) begin
      m_busy[r] = 0; m_tag[r] = 0; m_ready[r] = 0;
    end
  endtask

  task automatic idle();
    iss_vld = 0; iss_dst = 0; iss_tag = 0; iss_lat = 0;
    wb_vld = 0; wb_dst = 0; wb_tag = 0; flush = 0;
  endtask

  // Advance one edge, updating the model from the inputs applied to it.
  task automatic tick();
    int a;
    cyc++;
    if (reset || flush) begin
      model_clear();
    end else begin
      for (int j = 0; j < 2; j++) begin
        a = int'(wb_dst[j*7 +: 7]);
        if (wb_vld[j] && m_busy[a] && m_tag[a] == wb_tag[j*4 +: 4])
          m_busy[a] = 0;
      end
      for (int i = 0; i < 2; i++) begin
        a = int'(iss_dst[i*7 +: 7]);
        if (iss_vld[i] && a != 0) begin
          m_busy[a]  = 1;
          m_tag[a]   = iss_tag[i*4 +: 4];
          m_ready[a] = cyc + int'(iss_lat[i*3 +: 3]);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] model_out();
    logic [3:0] b, f;
    logic [7:0] c;
    int a;
    b = 0; f = 0; c = 0;
    for (int s = 0; s < 4; s++) begin
      a = int'(src_addr[s*7 +: 7]);
      b[s] = (a != 0) && m_busy[a];
      f[s] = b[s] && (cyc >= m_ready[a]);
    end
    for (int r = 0; r < 128; r++) c += 8'(m_busy[r]);
    return {b, f, c};
  endfunction

  initial begin
    tbl[0]  = v(0, 0,0,0, 0,0,0,  0, 0,0, 0,0,   4'h0, 4'h0, 0);
    tbl[1]  = v(1, 5,3,2, 0,0,0,  0, 0,0, 0,0,   4'h1, 4'h0, 1);
    tbl[2]  = v(0, 0,0,0, 0,0,0,  0, 0,0, 0,0,   4'h1, 4'h0, 1);
    tbl[3]  = v(0, 0,0,0, 0,0,0,  0, 0,0, 0,0,   4'h1, 4'h1, 1);
    tbl[4]  = v(0, 0,0,0, 0,0,0,  1, 5,3, 0,0,   4'h0, 4'h0, 0);
    tbl[5]  = v(1, 9,1,0, 0,0,0,  0, 0,0, 0,0,   4'h4, 4'h4, 1);
    tbl[6]  = v(1, 9,2,3, 0,0,0,  0, 0,0, 0,0,   4'h4, 4'h0, 1);
    tbl[7]  = v(0, 0,0,0, 0,0,0,  1, 9,1, 0,0,   4'h4, 4'h0, 1);
    tbl[8]  = v(0, 0,0,0, 0,0,0,  1, 9,2, 0,0,   4'h0, 4'h0, 0);
    tbl[9]  = v(1, 7,4,0, 0,0,0,  0, 0,0, 0,0,   4'h2, 4'h2, 1);
    tbl[10] = v(1, 7,5,1, 0,0,0,  1, 7,4, 0,0,   4'h2, 4'h0, 1);
    tbl[11] = v(0, 0,0,0, 0,0,0,  1, 7,4, 0,0,   4'h2, 4'h2, 1);
    tbl[12] = v(0, 0,0,0, 0,0,0,  1, 7,5, 0,0,   4'h0, 4'h0, 0);
    tbl[13] = v(3, 12,6,0, 12,7,2, 0, 0,0, 0,0,  4'h8, 4'h0, 1);
    tbl[14] = v(0, 0,0,0, 0,0,0,  1, 12,6, 0,0,  4'h8, 4'h0, 1);
    tbl[15] = v(1, 0,1,0, 0,0,0,  2, 0,0, 12,7,  4'h0, 4'h0, 0);
    tbl[16] = v(3, 5,9,0, 0,2,0,  3, 0,2, 5,0,   4'h1, 4'h1, 1);
    tbl[17] = v(0, 0,0,0, 0,0,0,  3, 9,0, 5,9,   4'h0, 4'h0, 0);

    model_clear();
    idle();
    src_addr = SRC_FIX;

    // Reset holds outputs at zero and swallows issues.
    reset = 1'b1;
    iss_vld = 2'b01; iss_dst = {7'd0, 7'd5}; iss_lat = 0; iss_tag = 3;
    tick();
    tick();
    chk("rst_busy", 32'(src_busy), 0);
    chk("rst_fwd", 32'(src_fwd), 0);
    chk("rst_cnt", 32'(busy_cnt), 0);
    #1 reset = 1'b0;
    idle();
    tick();
    chk("post_rst_busy", 32'(src_busy), 0);
    chk("post_rst_cnt", 32'(busy_cnt), 0);

    foreach (tbl[k]) begin
      iss_vld = tbl[k].iv;
      iss_dst = {tbl[k].d1, tbl[k].d0};
      iss_tag = {tbl[k].t1, tbl[k].t0};
      iss_lat = {tbl[k].l1, tbl[k].l0};
      wb_vld  = tbl[k].wv;
      wb_dst  = {tbl[k].wd1, tbl[k].wd0};
      wb_tag  = {tbl[k].wt1, tbl[k].wt0};
      tick();
      idle();
      #1;
      chk($sformatf("tbl%0d_busy", k), 32'(src_busy), 32'(tbl[k].eb));
      chk($sformatf("tbl%0d_fwd", k), 32'(src_fwd), 32'(tbl[k].ef));
      chk($sformatf("tbl%0d_cnt", k), 32'(busy_cnt), 32'(tbl[k].ec));
    end

    // Register 0 is never tracked.
    iss_vld = 2'b11; iss_dst = {7'd0, 7'd0}; iss_lat = 0;
    src_addr = {7'd0, 7'd0, 7'd0, 7'd0};
    tick();
    idle();
    #1;
    chk("r0_busy", 32'(src_busy), 0);
    chk("r0_fwd", 32'(src_fwd), 0);
    chk("r0_cnt", 32'(busy_cnt), 0);

    // Fill 20 registers, then flush.
    src_addr = SRC_FIX;
    for (int k = 0; k < 10; k++) begin
      iss_vld = 2'b11;
      iss_dst = {7'(21 + 2*k), 7'(20 + 2*k)};
      iss_tag = {4'(k), 4'(k)};
      iss_lat = {3'd7, 3'd7};
      tick();
    end
    idle();
    #1;
    chk("fill_cnt", 32'(busy_cnt), 20);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("flush_cnt", 32'(busy_cnt), 0);

    // Asynchronous reset in the middle of a countdown.
    iss_vld = 2'b11; iss_dst = {7'd9, 7'd5};
    iss_tag = {4'd2, 4'd1}; iss_lat = {3'd5, 3'd5};
    tick();
    idle();
    tick();
    chk("pre_areset_busy", 32'(src_busy), 32'h5);
    chk("pre_areset_cnt", 32'(busy_cnt), 2);
    #2 reset = 1'b1;
    #1;
    chk("areset_busy", 32'(src_busy), 0);
    chk("areset_cnt", 32'(busy_cnt), 0);
    model_clear();
    tick();
    #1 reset = 1'b0;
    tick();
    chk("areset_release", {src_busy, src_fwd, busy_cnt}, 0);

    // Randomized traffic on a small register window.
    for (int n = 0; n < 400; n++) begin
      logic [6:0] wd;
      iss_vld = 2'($urandom_range(0, 3));
      iss_dst = {7'($urandom_range(0, 15)), 7'($urandom_range(0, 15))};
      iss_tag = 8'($urandom);
      iss_lat = 6'($urandom);
      wb_vld  = 2'($urandom_range(0, 3));
      for (int j = 0; j < 2; j++) begin
        wd = 7'($urandom_range(0, 15));
        wb_dst[j*7 +: 7] = wd;
        wb_tag[j*4 +: 4] = ($urandom_range(0, 1) == 1) ?
                           m_tag[int'(wd)] : 4'($urandom);
      end
      flush = ($urandom_range(0, 39) == 0);
      tick();
      idle();
      src_addr = {7'($urandom_range(0, 15)), 7'($urandom_range(0, 15)),
                  7'($urandom_range(0, 15)), 7'($urandom_range(0, 15))};
      #1;
      chk($sformatf("rand%0d", n), {src_busy, src_fwd, busy_cnt}, 32'(model_out()));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
